period_timer: RTL and testbench
===============================

// Module: period_timer
// PURPOSE
//  Parametrised day/period timer for the seating system. A prescaler turns clk
//  into count ticks. A WIDTH-bit minute counter wraps at a programmable
//  reset_time and emits a day-end pulse. NUM_ALARMS compare channels flag
//  class-period boundaries. Feeds the seat allocator and per-day reset logic.
// PARAMETERS
//  WIDTH      11  counter / compare width (minutes)
//  NUM_ALARMS 4   number of compare channels, >=1
//  PRESCALE   1   clk cycles per count tick, >=1 (1 = count every enabled cycle)
//  DAY_W      8   width of completed-day counter
// PORTS
//  clk         in   1                 system clock, all logic on posedge
//  rst         in   1                 synchronous, active-high reset
//  en          in   1                 count enable; low = pause (prescaler holds)
//  reset_time  in   WIDTH             last count value of a day (period = reset_time+1)
//  alarm_time  in   NUM_ALARMS*WIDTH  compare values, channel i at [i*WIDTH +: WIDTH]
//  alarm_en    in   NUM_ALARMS        per-channel alarm enable
//  time_out    out  WIDTH             current count
//  rst_timer   out  1                 1-cycle day-end pulse
//  alarm_hit   out  NUM_ALARMS        1-cycle per-channel match pulse
//  day_count   out  DAY_W             completed days, wraps modulo 2^DAY_W
// BEHAVIOUR
//  - Reset (rst=1 at posedge): time_out=0, rst_timer=0, alarm_hit=0,
//    day_count=0, prescaler=0. Reset has priority over en and tick.
//  - Prescaler: 0..PRESCALE-1 while en=1. tick=1 in the cycle the prescaler
//    is at PRESCALE-1 and en=1; the prescaler then returns to 0.
//    en=0 holds the prescaler and the counter, and forces the pulses to 0.
//  - On tick:
//      if time_out >= reset_time: time_out<=0, rst_timer<=1, day_count<=day_count+1
//      else:                      time_out<=time_out+1, rst_timer<=0
//  - ">=" is deliberate. Lowering reset_time below the current count wraps on
//    the next tick; the counter never runs past reset_time.
//  - reset_time=0: every tick wraps and pulses rst_timer.
//  - rst_timer and alarm_hit are registered. Each is high only in the cycle
//    time_out first shows the new value, and low on all non-tick cycles.
//  - alarm_hit[i] <= tick & alarm_en[i] & (next_time == alarm_time[i]).
//    next_time is the value loaded into time_out on that tick.
//  - An alarm at 0 fires in the same cycle as rst_timer.
//  - Several channels may hit together.
//  - An alarm_time above reset_time never fires.
//  - A tick is the sole count event. No overflow: the count is bounded by
//    reset_time <= 2^WIDTH-1.
//  - Latency: with PRESCALE=1 and en=1, time_out advances every cycle.
//    The first increment is visible 1 cycle after rst deasserts.
// STRUCTURE
//  - timer_pkg: WIDTH/NUM_ALARMS/DAY_W defaults and a typedef logic[WIDTH-1:0] minute_t.
//  - Sub-module tick_prescaler(clk, rst, en, tick), parametrised by PRESCALE.
//    For PRESCALE=1 it degenerates to tick=en.
//  - The top holds the counter, the compare generate-loop and the day counter.
// TESTING
//  1. PRESCALE=1, reset_time=5, en=1 from reset:
//     - time_out 1,2,3,4,5,0,1.
//     - rst_timer=1 only with the first 0.
//     - day_count=1.
//  2. PRESCALE=3, reset_time=2:
//     - time_out steps every 3rd cycle.
//     - 9 cycles after rst deasserts it has returned to 0 with one rst_timer pulse.
//  3. Pause: drop en at time_out=3 for 10 cycles.
//     - time_out stays 3, no pulses.
//     - Resume gives 4 on the first enabled tick.
//  4. Alarms: alarm_time={0,3,3,9}, alarm_en=4'b1111, reset_time=5.
//     - Channels 1 and 2 pulse together at time_out=3.
//     - Channel 0 pulses with rst_timer.
//     - Channel 3 never pulses.
//     - alarm_en[1]=0 suppresses channel 1.
//  5. At time_out=8 change reset_time 20->4:
//     - Next tick gives time_out=0, rst_timer=1.
//  6. Assert rst mid-count (time_out=7, prescaler mid-cycle):
//     - All outputs 0 next cycle.
//     - Count restarts from 0 with a full prescale interval.
//  7. DAY_W=2: after 4 day wraps, day_count returns to 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared defaults and types for the seating-system day/period timer.
package timer_pkg;

  localparam int TIMER_WIDTH      = 11;
  localparam int TIMER_NUM_ALARMS = 4;
  localparam int TIMER_DAY_W      = 8;

  typedef logic [TIMER_WIDTH-1:0] minute_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clk cycles into count ticks; one tick every PRESCALE enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // With PRESCALE=1 the counter is a constant 0 and tick reduces to en.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/period_timer.sv
// Minute counter wrapping at reset_time, with day-end pulse, day counter and compare alarms.
module period_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = TIMER_WIDTH,
  parameter int NUM_ALARMS = TIMER_NUM_ALARMS,
  parameter int PRESCALE   = 1,
  parameter int DAY_W      = TIMER_DAY_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            reset_time,
  input  logic [NUM_ALARMS*WIDTH-1:0] alarm_time,
  input  logic [NUM_ALARMS-1:0]       alarm_en,
  output logic [WIDTH-1:0]            time_out,
  output logic                        rst_timer,
  output logic [NUM_ALARMS-1:0]       alarm_hit,
  output logic [DAY_W-1:0]            day_count
);

  logic                  tick;
  logic                  wrap;
  logic [WIDTH-1:0]      next_time;
  logic [NUM_ALARMS-1:0] hit_next;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // ">=" so a reset_time lowered below the current count wraps on the next tick.
  assign wrap      = (time_out >= reset_time);
  assign next_time = wrap ? '0 : time_out + 1'b1;

  // Alarms compare against the value being loaded, so they line up with time_out.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    assign hit_next[i] = alarm_en[i] && (next_time == alarm_time[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_out  <= '0;
      rst_timer <= 1'b0;
      alarm_hit <= '0;
      day_count <= '0;
    end else if (tick) begin
      time_out  <= next_time;
      rst_timer <= wrap;
      alarm_hit <= hit_next;
      if (wrap) begin
        day_count <= day_count + 1'b1;
      end
    end else begin
      rst_timer <= 1'b0;
      alarm_hit <= '0;
    end
  end

endmodule

// File: tb/tb_period_timer.sv
// Bench for period_timer: three instances (PRESCALE 1/3, DAY_W 8/2) against a behavioural model.
module tb_period_timer;
  import timer_pkg::*;

  localparam int W  = TIMER_WIDTH;
  localparam int NA = TIMER_NUM_ALARMS;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic [W-1:0]    reset_time = '0;
  logic [NA*W-1:0] alarm_time = '0;
  logic [NA-1:0]   alarm_en   = '0;

  always #5 clk = ~clk;

  minute_t       time_a, time_b, time_c;
  logic          rt_a, rt_b, rt_c;
  logic [NA-1:0] hit_a, hit_b, hit_c;
  logic [7:0]    day_a, day_b;
  logic [1:0]    day_c;

  period_timer #(.PRESCALE(1), .DAY_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .reset_time(reset_time), .alarm_time(alarm_time),
    .alarm_en(alarm_en), .time_out(time_a), .rst_timer(rt_a), .alarm_hit(hit_a), .day_count(day_a)
  );
  period_timer #(.PRESCALE(3), .DAY_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .reset_time(reset_time), .alarm_time(alarm_time),
    .alarm_en(alarm_en), .time_out(time_b), .rst_timer(rt_b), .alarm_hit(hit_b), .day_count(day_b)
  );
  period_timer #(.PRESCALE(1), .DAY_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .reset_time(reset_time), .alarm_time(alarm_time),
    .alarm_en(alarm_en), .time_out(time_c), .rst_timer(rt_c), .alarm_hit(hit_c), .day_count(day_c)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Behavioural model: counts enabled cycles since reset, ticks every P-th one.
  function automatic int pre_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int day_mod(input int i);
    return (i == 2) ? 4 : 256;
  endfunction

  int            m_time[3];
  int            m_day[3];
  int            m_en_cycles[3];
  bit            m_rt[3];
  logic [NA-1:0] m_hit[3];
  bit            m_valid = 1'b0;
  bit            m_tick;
  int            m_next;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_time[i] = 0; m_day[i] = 0; m_en_cycles[i] = 0; m_rt[i] = 1'b0; m_hit[i] = '0;
      end else begin
        m_tick = en && ((m_en_cycles[i] % pre_of(i)) == pre_of(i) - 1);
        if (en) m_en_cycles[i]++;
        if (m_tick) begin
          m_rt[i] = (m_time[i] >= int'(reset_time));
          m_next  = m_rt[i] ? 0 : m_time[i] + 1;
          if (m_rt[i]) m_day[i]++;
          for (int c = 0; c < NA; c++)
            m_hit[i][c] = alarm_en[c] && (m_next == int'(alarm_time[c*W +: W]));
          m_time[i] = m_next;
        end else begin
          m_rt[i]  = 1'b0;
          m_hit[i] = '0;
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Per-cycle comparison against the model.
  bit ch3_seen = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_a_time", 32'(time_a), m_time[0]);
      check("cmp_a_rst_timer", 32'(rt_a), 32'(m_rt[0]));
      check("cmp_a_alarm", 32'(hit_a), 32'(m_hit[0]));
      check("cmp_a_day", 32'(day_a), m_day[0] % day_mod(0));
      check("cmp_b_time", 32'(time_b), m_time[1]);
      check("cmp_b_rst_timer", 32'(rt_b), 32'(m_rt[1]));
      check("cmp_b_alarm", 32'(hit_b), 32'(m_hit[1]));
      check("cmp_b_day", 32'(day_b), m_day[1] % day_mod(1));
      check("cmp_c_time", 32'(time_c), m_time[2]);
      check("cmp_c_rst_timer", 32'(rt_c), 32'(m_rt[2]));
      check("cmp_c_alarm", 32'(hit_c), 32'(m_hit[2]));
      check("cmp_c_day", 32'(day_c), m_day[2] % day_mod(2));
    end
    if (hit_a[3] || hit_b[3] || hit_c[3]) ch3_seen = 1'b1;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    check("rst_a_time", 32'(time_a), 0);
    check("rst_b_time", 32'(time_b), 0);
    check("rst_c_time", 32'(time_c), 0);
    check("rst_pulses", 32'({rt_a, rt_b, rt_c, hit_a, hit_b, hit_c}), 0);
    check("rst_days", 32'({day_a, day_b, day_c}), 0);
    rst = 1'b0;
  endtask

  int seq_t[7]  = '{1, 2, 3, 4, 5, 0, 1};
  int seq_rt[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    // 1: basic count with alarms {ch3=9, ch2=3, ch1=3, ch0=0}
    en         = 1'b1;
    reset_time = 11'd5;
    alarm_time = {11'd9, 11'd3, 11'd3, 11'd0};
    alarm_en   = 4'b1111;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(1);
      check("seq_time", 32'(time_a), seq_t[k]);
      check("seq_rst_timer", 32'(rt_a), seq_rt[k]);
      if (k == 2) check("alarm_at_3", 32'(hit_a), 32'h6);
      if (k == 5) check("alarm_at_0", 32'(hit_a), 32'h1);
    end
    check("day_after_wrap", 32'(day_a), 1);

    // 2: PRESCALE=3, reset_time=2
    reset_time = 11'd2;
    do_reset();
    step(8);
    check("pre3_time_c8", 32'(time_b), 2);
    check("pre3_rst_c8", 32'(rt_b), 0);
    step(1);
    check("pre3_time_c9", 32'(time_b), 0);
    check("pre3_rst_c9", 32'(rt_b), 1);
    check("pre3_day_c9", 32'(day_b), 1);

    // 3/4: pause at 3, resume, then suppress channel 1
    reset_time = 11'd5;
    do_reset();
    step(3);
    check("pause_start", 32'(time_a), 3);
    en = 1'b0;
    step(10);
    check("pause_hold", 32'(time_a), 3);
    check("pause_pulses", 32'({rt_a, hit_a}), 0);
    en       = 1'b1;
    alarm_en = 4'b1101;
    step(1);
    check("resume_time", 32'(time_a), 4);
    step(2);
    check("resume_wrap", 32'({rt_a, hit_a}), 32'h11);
    step(3);
    check("ch1_suppressed", 32'(hit_a), 32'h4);
    check("ch3_never", 32'(ch3_seen), 0);

    // 5: lower reset_time below current count
    alarm_en   = 4'b1111;
    reset_time = 11'd20;
    do_reset();
    step(8);
    check("lower_before", 32'(time_a), 8);
    reset_time = 11'd4;
    step(1);
    check("lower_time", 32'(time_a), 0);
    check("lower_rst", 32'(rt_a), 1);

    // 6: reset mid-count with prescaler mid-interval
    alarm_en   = '0;
    reset_time = 11'd20;
    do_reset();
    step(22);
    check("mid_time_b", 32'(time_b), 7);
    do_reset();
    step(2);
    check("restart_b_hold", 32'(time_b), 0);
    step(1);
    check("restart_b_first", 32'(time_b), 1);

    // 7: reset_time=0 wraps every tick; DAY_W=2 rolls over
    reset_time = 11'd0;
    do_reset();
    step(3);
    check("day2_three", 32'(day_c), 3);
    check("day2_time", 32'(time_c), 0);
    check("day2_rst", 32'(rt_c), 1);
    step(1);
    check("day2_wrap", 32'(day_c), 0);
    check("day8_four", 32'(day_a), 4);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
